// File: rtl/vga_timing_detector_if.sv
// Bundles the sync input side and the measurement/address outputs of the VGA timing detector.
//   slave  : the detector (consumes strobe + syncs, drives measurements and addresses)
//   master : the source/consumer side (drives strobe + syncs, reads results)
// Signals:
//   pix_en, hsync_in, vsync_in                  : pixel strobe and active-low syncs
//   h_total, h_sync_w, v_total, v_sync_w        : latched per-frame measurements
//   meas_valid, err                             : one-cycle pulses
//   locked, active, col_addr, row_addr          : lock status and regenerated raster position
interface vga_timing_detector_if #(
  parameter int unsigned CNT_W = 11
);
  logic             pix_en;
  logic             hsync_in;
  logic             vsync_in;
  logic [CNT_W-1:0] h_total;
  logic [CNT_W-1:0] h_sync_w;
  logic [CNT_W-1:0] v_total;
  logic [CNT_W-1:0] v_sync_w;
  logic             meas_valid;
  logic             locked;
  logic             err;
  logic             active;
  logic [CNT_W-1:0] col_addr;
  logic [CNT_W-1:0] row_addr;

  modport master (
    output pix_en, hsync_in, vsync_in,
    input  h_total, h_sync_w, v_total, v_sync_w, meas_valid, locked, err, active,
           col_addr, row_addr
  );

  modport slave (
    input  pix_en, hsync_in, vsync_in,
    output h_total, h_sync_w, v_total, v_sync_w, meas_valid, locked, err, active,
           col_addr, row_addr
  );
endinterface

// File: rtl/vga_timing_detector.sv
// Receive-side VGA timing detector: samples HSYNC/VSYNC on pix_en strobes, measures line and
// frame timing, locks after LOCK_FRAMES consecutive matching frames and regenerates the
// active-area flag with column/row addresses.
// Ports:
//   vga_clk : sampling clock
//   rst_n   : asynchronous active-low reset
//   vga_io  : slave side of vga_timing_detector_if (strobe/sync inputs, measurement outputs)
module vga_timing_detector #(
  parameter int unsigned CNT_W       = 11,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned H_START     = 216,
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_START     = 27,
  parameter int unsigned V_ACTIVE    = 600
) (
  input  logic                  vga_clk,
  input  logic                  rst_n,
  vga_timing_detector_if.slave  vga_io
);

  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] HStart     = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] HEnd       = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] VStart     = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] VEnd       = CNT_W'(V_START + V_ACTIVE);
  localparam logic [2:0]       LockFrames = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {StSearch, StArmed, StMeasure, StLocked} state_e;

  state_e state_q, state_d;
  logic [2:0] match_q, match_d, match_inc;

  // Sync samplers; vsync is only looked at on line events, so one stage suffices there.
  logic hs_s1_q, hs_s2_q, vs_s1_q;
  logic vs_prev_q, vs_prev_d;  // vsync level seen at the previous line event

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, line_len_q, line_len_d;
  logic [CNT_W-1:0] hs_w_q, hs_w_d, hs_len_q, hs_len_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d, frame_lines_q, frame_lines_d;
  logic [CNT_W-1:0] vs_w_q, vs_w_d, vs_len_q, vs_len_d;

  logic [CNT_W-1:0] h_total_q, h_sync_w_q, v_total_q, v_sync_w_q;
  logic             meas_valid_q, err_q, locked_q, active_q;
  logic [CNT_W-1:0] col_q, row_q;

  logic             sample, hs_fall, hs_rise, line_ev, frame_start, timeout;
  logic [CNT_W-1:0] line_len_new, frame_lines_new;
  logic             set_eq, latch, err_d;
  logic             act_d;
  logic [CNT_W-1:0] col_d, row_d;

  assign sample          = vga_io.pix_en;
  assign hs_fall         = hs_s2_q & ~hs_s1_q;
  assign hs_rise         = ~hs_s2_q & hs_s1_q;
  assign line_ev         = sample & hs_fall;
  assign frame_start     = line_ev & ~vs_s1_q & vs_prev_q;
  // Saturated line counter means no hsync edge for a whole counter range.
  assign timeout         = sample & ~hs_fall & (h_cnt_q == CntMax);
  assign line_len_new    = h_cnt_q + CntOne;
  assign frame_lines_new = v_cnt_q + CntOne;
  assign match_inc       = match_q + 3'd1;

  // The candidate frame set is the line/frame just completed plus the latest latched widths.
  assign set_eq = (line_len_new == h_total_q) && (hs_len_q == h_sync_w_q) &&
                  (frame_lines_new == v_total_q) && (vs_len_q == v_sync_w_q);

  // Line and frame measurement counters.
  always_comb begin
    h_cnt_d       = h_cnt_q;
    line_len_d    = line_len_q;
    hs_w_d        = hs_w_q;
    hs_len_d      = hs_len_q;
    v_cnt_d       = v_cnt_q;
    frame_lines_d = frame_lines_q;
    vs_w_d        = vs_w_q;
    vs_len_d      = vs_len_q;
    vs_prev_d     = vs_prev_q;
    if (sample) begin
      if (hs_fall) begin
        h_cnt_d    = '0;
        line_len_d = line_len_new;
      end else if (h_cnt_q != CntMax) begin
        h_cnt_d = h_cnt_q + CntOne;
      end

      if (hs_rise) begin
        hs_len_d = hs_w_q;
        hs_w_d   = '0;
      end else if (!hs_s1_q && (hs_w_q != CntMax)) begin
        hs_w_d = hs_w_q + CntOne;
      end

      if (hs_fall) begin
        vs_prev_d = vs_s1_q;
        if (frame_start) begin
          v_cnt_d       = '0;
          frame_lines_d = frame_lines_new;
        end else if (v_cnt_q != CntMax) begin
          v_cnt_d = v_cnt_q + CntOne;
        end
        if (!vs_s1_q) begin
          if (vs_w_q != CntMax) vs_w_d = vs_w_q + CntOne;
        end else if (!vs_prev_q) begin
          vs_len_d = vs_w_q;
          vs_w_d   = '0;
        end
      end
    end
  end

  // Lock FSM: next state, match counting, latch and error strobes.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    latch   = 1'b0;
    err_d   = 1'b0;
    if (timeout) begin
      state_d = StSearch;
      match_d = '0;
      err_d   = (state_q == StLocked);
    end else if (line_ev) begin
      case (state_q)
        StSearch: begin
          if (frame_start) begin
            state_d = StArmed;
            match_d = '0;
          end
        end
        StArmed: begin
          if (frame_start) begin
            latch   = 1'b1;
            state_d = StMeasure;
          end
        end
        StMeasure: begin
          if (frame_start) begin
            latch = 1'b1;
            if (set_eq) begin
              match_d = match_inc;
              if (match_inc == LockFrames) state_d = StLocked;
            end else begin
              match_d = '0;
            end
          end else if (line_len_new != line_len_q) begin
            match_d = '0;
          end
        end
        StLocked: begin
          if ((line_len_new != h_total_q) || (frame_start && !set_eq)) begin
            state_d = StSearch;
            match_d = '0;
            err_d   = 1'b1;
          end else if (frame_start) begin
            latch = 1'b1;
          end
        end
      endcase
    end
  end

  // Active-area decode from the current raster position.
  always_comb begin
    act_d = locked_q && (h_cnt_q >= HStart) && (h_cnt_q < HEnd) &&
            (v_cnt_q >= VStart) && (v_cnt_q < VEnd);
    col_d = act_d ? (h_cnt_q - HStart) : '0;
    row_d = act_d ? (v_cnt_q - VStart) : '0;
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StSearch;
      match_q       <= '0;
      hs_s1_q       <= 1'b1;
      hs_s2_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= '0;
      line_len_q    <= '0;
      hs_w_q        <= '0;
      hs_len_q      <= '0;
      v_cnt_q       <= '0;
      frame_lines_q <= '0;
      vs_w_q        <= '0;
      vs_len_q      <= '0;
      h_total_q     <= '0;
      h_sync_w_q    <= '0;
      v_total_q     <= '0;
      v_sync_w_q    <= '0;
      meas_valid_q  <= 1'b0;
      err_q         <= 1'b0;
      locked_q      <= 1'b0;
      active_q      <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
    end else begin
      if (sample) begin
        hs_s1_q  <= vga_io.hsync_in;
        hs_s2_q  <= hs_s1_q;
        vs_s1_q  <= vga_io.vsync_in;
        state_q  <= state_d;
        match_q  <= match_d;
        locked_q <= (state_d == StLocked);
      end
      if (latch) begin
        h_total_q  <= line_len_new;
        h_sync_w_q <= hs_len_q;
        v_total_q  <= frame_lines_new;
        v_sync_w_q <= vs_len_q;
      end
      h_cnt_d_reg: begin end
      h_cnt_q       <= h_cnt_d;
      line_len_q    <= line_len_d;
      hs_w_q        <= hs_w_d;
      hs_len_q      <= hs_len_d;
      v_cnt_q       <= v_cnt_d;
      frame_lines_q <= frame_lines_d;
      vs_w_q        <= vs_w_d;
      vs_len_q      <= vs_len_d;
      vs_prev_q     <= vs_prev_d;
      // Pulses are refreshed every clock so they last exactly one vga_clk.
      meas_valid_q  <= latch;
      err_q         <= err_d;
      active_q      <= act_d;
      col_q         <= col_d;
      row_q         <= row_d;
    end
  end

  assign vga_io.h_total    = h_total_q;
  assign vga_io.h_sync_w   = h_sync_w_q;
  assign vga_io.v_total    = v_total_q;
  assign vga_io.v_sync_w   = v_sync_w_q;
  assign vga_io.meas_valid = meas_valid_q;
  assign vga_io.err        = err_q;
  assign vga_io.locked     = locked_q;
  assign vga_io.active     = active_q;
  assign vga_io.col_addr   = col_q;
  assign vga_io.row_addr   = row_q;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench for vga_timing_detector using a reduced raster (40 px/line, hsync 6, 20 lines,
// vsync 2, active 24x12 at h 10 / v 4) so that several frames fit in a short run.
module tb_vga_timing_detector;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LOCK  = 2;
  localparam int unsigned HS    = 10;
  localparam int unsigned HA    = 24;
  localparam int unsigned VS    = 4;
  localparam int unsigned VA    = 12;
  localparam int HTOT = 40;
  localparam int HSW  = 6;
  localparam int VTOT = 20;
  localparam int VSW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_detector_if #(.CNT_W(CNT_W)) vif ();

  vga_timing_detector #(
    .CNT_W(CNT_W), .LOCK_FRAMES(LOCK), .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA)
  ) dut (
    .vga_clk(clk),
    .rst_n  (rst_n),
    .vga_io (vif)
  );

  int vectors = 0;
  int miscompares = 0;

  int div = 1;
  int cur_frame = 0, cur_line = 0, cur_pix = 0;
  int mv_cnt = 0, err_cnt = 0, act_cnt = 0, addr_bad = 0, act_bad = 0, err_lock_bad = 0;
  int lock_frame = -1, mv_first_frame = -1;
  logic locked_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Event monitor: active for pixel p appears while pixel p+2 is being driven.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (vif.meas_valid) begin
        mv_cnt++;
        if (mv_first_frame < 0) mv_first_frame = cur_frame;
      end
      if (vif.err) begin
        err_cnt++;
        if (vif.locked) err_lock_bad++;
      end
      if (vif.locked && !locked_prev) lock_frame = cur_frame;
      if (vif.active) begin
        act_cnt++;
        if (!locked_prev) act_bad++;
        if ((int'(vif.col_addr) != cur_pix - int'(HS) - 2) ||
            (int'(vif.row_addr) != cur_line - int'(VS))) addr_bad++;
      end else if ((vif.col_addr != '0) || (vif.row_addr != '0)) begin
        addr_bad++;
      end
      locked_prev = vif.locked;
    end else begin
      locked_prev = 1'b0;
    end
  end

  task automatic send_pixel(input logic hs, input logic vs, input int l, input int p);
    for (int c = 0; c < div; c++) begin
      @(negedge clk);
      vif.hsync_in = hs;
      vif.vsync_in = vs;
      vif.pix_en   = (c == div - 1);
      cur_line     = l;
      cur_pix      = p;
    end
  endtask

  task automatic send_line(input int l, input int len);
    for (int p = 0; p < len; p++) send_pixel(p >= HSW, l >= VSW, l, p);
  endtask

  task automatic send_frame(input int short_line);
    for (int l = 0; l < VTOT; l++) send_line(l, (l == short_line) ? HTOT - 1 : HTOT);
  endtask

  task automatic check_meas(input string tag);
    check({tag, "_h_total"}, vif.h_total, HTOT);
    check({tag, "_h_sync_w"}, vif.h_sync_w, HSW);
    check({tag, "_v_total"}, vif.v_total, VTOT);
    check({tag, "_v_sync_w"}, vif.v_sync_w, VSW);
  endtask

  int n;

  initial begin
    vif.pix_en   = 1'b0;
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_h_total", vif.h_total, 0);
    check("rst_v_total", vif.v_total, 0);
    check("rst_locked", vif.locked, 0);
    check("rst_active", vif.active, 0);
    check("rst_meas_valid", vif.meas_valid, 0);
    check("rst_err", vif.err, 0);
    rst_n = 1'b1;

    // 1:1 stream: measure, lock at the 4th frame start, active area in a locked frame.
    for (int f = 0; f < 5; f++) begin
      cur_frame = f;
      if (f == 4) act_cnt = 0;
      send_frame(-1);
      if (f == 1) begin
        check_meas("f1");
        check("f1_mv_cnt", mv_cnt, 1);
        check("f1_mv_first", mv_first_frame, 1);
      end
      if (f == 2) check("f2_locked", vif.locked, 0);
    end
    check("lock_frame", lock_frame, 3);
    check("locked", vif.locked, 1);
    check("mv_cnt_f4", mv_cnt, 4);
    check("active_count", act_cnt, HA * VA);
    check("addr_bad", addr_bad, 0);
    check("act_bad", act_bad, 0);
    check("err_none", err_cnt, 0);

    // Shortened line while locked.
    cur_frame = 5;
    send_frame(10);
    check("short_err", err_cnt, 1);
    check("short_locked", vif.locked, 0);
    check("short_err_lock", err_lock_bad, 0);
    for (int f = 6; f < 10; f++) begin
      cur_frame = f;
      send_frame(-1);
      if (f == 8) check("short_f8_locked", vif.locked, 0);
    end
    check("relock_frame", lock_frame, 9);
    check("relock_mv_cnt", mv_cnt, 8);
    check("relock_act_bad", act_bad, 0);

    // Syncs held high while locked: timeout when the line counter saturates.
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      vif.hsync_in = 1'b1;
      vif.vsync_in = 1'b1;
      vif.pix_en   = 1'b1;
      @(posedge clk);
      #1;
      if (vif.err) begin
        n = i;
        break;
      end
    end
    check("timeout_samples", n, 218);
    check("timeout_locked", vif.locked, 0);
    repeat (20) @(negedge clk);
    check("timeout_err_cnt", err_cnt, 2);

    // Restart stream and relock.
    for (int f = 10; f < 14; f++) begin
      cur_frame = f;
      send_frame(-1);
    end
    check("restart_lock_frame", lock_frame, 13);
    check("restart_mv_cnt", mv_cnt, 11);
    check_meas("restart");

    // Asynchronous reset in the middle of line 10, inside the active window.
    cur_frame = 14;
    for (int l = 0; l < 10; l++) send_line(l, HTOT);
    for (int p = 0; p < 20; p++) send_pixel(p >= HSW, 1'b1, 10, p);
    @(posedge clk);
    #2;
    check("pre_rst_active", vif.active, 1);
    check("pre_rst_locked", vif.locked, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_active", vif.active, 0);
    check("mid_rst_locked", vif.locked, 0);
    check("mid_rst_col", vif.col_addr, 0);
    check("mid_rst_row", vif.row_addr, 0);
    check("mid_rst_h_total", vif.h_total, 0);
    check("mid_rst_v_sync_w", vif.v_sync_w, 0);
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    vif.pix_en   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Same stream on a 1-in-5 pixel strobe after reset.
    div = 5;
    mv_cnt = 0;
    lock_frame = -1;
    mv_first_frame = -1;
    for (int f = 0; f < 5; f++) begin
      cur_frame = f;
      if (f == 4) act_cnt = 0;
      send_frame(-1);
      if (f == 1) begin
        check_meas("div5_f1");
        check("div5_mv_first", mv_first_frame, 1);
      end
    end
    check("div5_lock_frame", lock_frame, 3);
    check("div5_mv_cnt", mv_cnt, 4);
    check("div5_active_count", act_cnt, 5 * HA * VA);
    check("div5_addr_bad", addr_bad, 0);
    check("div5_act_bad", act_bad, 0);
    check("div5_err_cnt", err_cnt, 2);
    check("div5_locked", vif.locked, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
